// File: rtl/reg_wb_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_wb_ctrl : in-order writeback queue feeding the register-file write port,
//               with two-operand youngest-match forwarding.   Rev 1.0
// ---------------------------------------------------------------------------
module reg_wb_ctrl #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [ADDR_W-1:0]            mem_reg,
  input  logic [DATA_W-1:0]            mem_data,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [ADDR_W-1:0]            alu_reg,
  input  logic [DATA_W-1:0]            alu_data,
  output logic [ADDR_W-1:0]            wr_reg_num,
  output logic [DATA_W-1:0]            wr_data,
  output logic                         reg_write,
  input  logic [ADDR_W-1:0]            fwd_reg1,
  input  logic [ADDR_W-1:0]            fwd_reg2,
  output logic                         fwd_hit1,
  output logic                         fwd_hit2,
  output logic [DATA_W-1:0]            fwd_data1,
  output logic [DATA_W-1:0]            fwd_data2,
  output logic [$clog2(DEPTH+1)-1:0]   pending_count,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [ADDR_W-1:0] reg_q  [DEPTH];
  logic [ADDR_W-1:0] reg_d  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d, alu_slot;
  logic [CW-1:0]     count_q, count_d, free;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] wr_reg_num_q, wr_reg_num_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              mem_enq, alu_enq, deq;

  // Free space ignores a same-cycle pop, so readies never depend on dequeue.
  assign free      = C_DEPTH - count_q;
  assign mem_ready = reset & (free >= CW'(1));
  assign alu_ready = reset & ((free >= CW'(2)) | ((free == CW'(1)) & ~mem_valid));

  // r0 writes complete the handshake but never occupy a slot.
  assign mem_enq = mem_valid & mem_ready & (mem_reg != '0);
  assign alu_enq = alu_valid & alu_ready & (alu_reg != '0);
  assign deq     = (count_q != '0);

  always_comb begin
    reg_d        = reg_q;
    data_d       = data_q;
    head_d       = head_q;
    reg_write_d  = 1'b0;
    wr_reg_num_d = wr_reg_num_q;
    wr_data_d    = wr_data_q;
    if (deq) begin
      reg_write_d  = 1'b1;
      wr_reg_num_d = reg_q[head_q];
      wr_data_d    = data_q[head_q];
      head_d       = head_q + PW'(1);
    end
    alu_slot = tail_q + PW'(mem_enq);
    if (mem_enq) begin
      reg_d[tail_q]  = mem_reg;
      data_d[tail_q] = mem_data;
    end
    if (alu_enq) begin
      reg_d[alu_slot]  = alu_reg;
      data_d[alu_slot] = alu_data;
    end
    tail_d  = alu_slot + PW'(alu_enq);
    count_d = count_q + CW'(mem_enq) + CW'(alu_enq) - CW'(deq);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      wr_reg_num_q <= '0;
      wr_data_q    <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      reg_write_q  <= reg_write_d;
      wr_reg_num_q <= wr_reg_num_d;
      wr_data_q    <= wr_data_d;
    end
  end

  always_ff @(posedge clock) begin
    reg_q  <= reg_d;
    data_q <= data_d;
  end

  // Scan oldest to youngest so the last match is the youngest value.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    if (reg_write_q && (wr_reg_num_q == fwd_reg1)) begin
      fwd_hit1  = 1'b1;
      fwd_data1 = wr_data_q;
    end
    if (reg_write_q && (wr_reg_num_q == fwd_reg2)) begin
      fwd_hit2  = 1'b1;
      fwd_data2 = wr_data_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if ((CW'(k) < count_q) && (reg_q[idx] == fwd_reg1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = data_q[idx];
      end
      if ((CW'(k) < count_q) && (reg_q[idx] == fwd_reg2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = data_q[idx];
      end
    end
    if (fwd_reg1 == '0) begin
      fwd_hit1  = 1'b0;
      fwd_data1 = '0;
    end
    if (fwd_reg2 == '0) begin
      fwd_hit2  = 1'b0;
      fwd_data2 = '0;
    end
  end

  assign wr_reg_num    = wr_reg_num_q;
  assign wr_data       = wr_data_q;
  assign reg_write     = reg_write_q;
  assign pending_count = count_q;
  assign empty         = (count_q == '0) & ~reg_write_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_reg_wb_ctrl : directed vector table plus backpressure scoreboard.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_reg_wb_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_valid, alu_valid, mem_ready, alu_ready;
  logic [4:0]  mem_reg, alu_reg, wr_reg_num, fwd_reg1, fwd_reg2;
  logic [31:0] mem_data, alu_data, wr_data, fwd_data1, fwd_data2;
  logic        reg_write, fwd_hit1, fwd_hit2, empty;
  logic [2:0]  pending_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  reg_wb_ctrl #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clock(clock), .reset(reset),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .wr_reg_num(wr_reg_num), .wr_data(wr_data), .reg_write(reg_write),
    .fwd_reg1(fwd_reg1), .fwd_reg2(fwd_reg2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .pending_count(pending_count), .empty(empty)
  );

  typedef struct {
    logic        rst;
    logic        mv;  logic [4:0] mr; logic [31:0] md;
    logic        av;  logic [4:0] ar; logic [31:0] ad;
    logic [4:0]  f1;  logic [4:0] f2;
    logic        mrdy; logic ardy; logic we; logic [4:0] wreg; logic [31:0] wdata;
    logic [2:0]  cnt;  logic h1; logic [31:0] d1; logic h2; logic [31:0] d2; logic emp;
  } vec_t;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    ent_t        q[$];
    ent_t        e;
    logic        exp_we, em, ea, done;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    int          mi, ai, retired;

    // Outputs in each row are the state seen before that row's clock edge.
    //          rst mv mr  md            av ar  ad            f1 f2  mrdy ardy we wreg wdata         cnt h1 d1            h2 d2  emp
    vecs[0]  = '{0, 0, 0,  0,            0, 0,  0,            0, 0,  0, 0,  0, 0,  0,            0, 0, 0,            0, 0,  1};
    vecs[1]  = '{1, 0, 0,  0,            1, 5,  32'hDEADBEEF, 5, 0,  1, 1,  0, 0,  0,            0, 0, 0,            0, 0,  1};
    vecs[2]  = '{1, 0, 0,  0,            0, 0,  0,            5, 0,  1, 1,  0, 0,  0,            1, 1, 32'hDEADBEEF, 0, 0,  0};
    vecs[3]  = '{1, 0, 0,  0,            0, 0,  0,            5, 0,  1, 1,  1, 5,  32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 0, 0,  0};
    vecs[4]  = '{1, 0, 0,  0,            0, 0,  0,            5, 0,  1, 1,  0, 5,  32'hDEADBEEF, 0, 0, 0,            0, 0,  1};
    vecs[5]  = '{1, 1, 3,  32'h11111111, 1, 3,  32'h22222222, 3, 0,  1, 1,  0, 5,  32'hDEADBEEF, 0, 0, 0,            0, 0,  1};
    vecs[6]  = '{1, 0, 0,  0,            0, 0,  0,            3, 0,  1, 1,  0, 5,  32'hDEADBEEF, 2, 1, 32'h22222222, 0, 0,  0};
    vecs[7]  = '{1, 0, 0,  0,            0, 0,  0,            3, 0,  1, 1,  1, 3,  32'h11111111, 1, 1, 32'h22222222, 0, 0,  0};
    vecs[8]  = '{1, 0, 0,  0,            0, 0,  0,            3, 0,  1, 1,  1, 3,  32'h22222222, 0, 1, 32'h22222222, 0, 0,  0};
    vecs[9]  = '{1, 0, 0,  0,            0, 0,  0,            3, 0,  1, 1,  0, 3,  32'h22222222, 0, 0, 0,            0, 0,  1};
    vecs[10] = '{1, 0, 0,  0,            1, 0,  32'hFFFFFFFF, 0, 0,  1, 1,  0, 3,  32'h22222222, 0, 0, 0,            0, 0,  1};
    vecs[11] = '{1, 0, 0,  0,            0, 0,  0,            0, 0,  1, 1,  0, 3,  32'h22222222, 0, 0, 0,            0, 0,  1};
    vecs[12] = '{1, 0, 0,  0,            1, 7,  32'hA,        7, 8,  1, 1,  0, 3,  32'h22222222, 0, 0, 0,            0, 0,  1};
    vecs[13] = '{1, 0, 0,  0,            1, 7,  32'hB,        7, 8,  1, 1,  0, 3,  32'h22222222, 1, 1, 32'hA,        0, 0,  0};
    vecs[14] = '{1, 0, 0,  0,            0, 0,  0,            7, 8,  1, 1,  1, 7,  32'hA,        1, 1, 32'hB,        0, 0,  0};
    vecs[15] = '{1, 0, 0,  0,            0, 0,  0,            7, 8,  1, 1,  1, 7,  32'hB,        0, 1, 32'hB,        0, 0,  0};
    vecs[16] = '{1, 0, 0,  0,            0, 0,  0,            7, 8,  1, 1,  0, 7,  32'hB,        0, 0, 0,            0, 0,  1};
    vecs[17] = '{1, 1, 9,  32'h9,        1, 10, 32'h10,       9, 10, 1, 1,  0, 7,  32'hB,        0, 0, 0,            0, 0,  1};
    vecs[18] = '{1, 1, 11, 32'h11,       1, 12, 32'h12,       9, 10, 1, 1,  0, 7,  32'hB,        2, 1, 32'h9,        1, 32'h10, 0};
    vecs[19] = '{0, 1, 13, 32'h13,       0, 0,  0,            9, 10, 0, 0,  1, 9,  32'h9,        3, 1, 32'h9,        1, 32'h10, 0};
    vecs[20] = '{1, 0, 0,  0,            0, 0,  0,            9, 10, 1, 1,  0, 0,  0,            0, 0, 0,            0, 0,  1};
    vecs[21] = '{1, 0, 0,  0,            0, 0,  0,            9, 10, 1, 1,  0, 0,  0,            0, 0, 0,            0, 0,  1};

    reset = 1'b0;
    mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    fwd_reg1 = '0; fwd_reg2 = '0;
    repeat (2) @(posedge clock);

    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      reset     = vecs[i].rst;
      mem_valid = vecs[i].mv; mem_reg = vecs[i].mr; mem_data = vecs[i].md;
      alu_valid = vecs[i].av; alu_reg = vecs[i].ar; alu_data = vecs[i].ad;
      fwd_reg1  = vecs[i].f1; fwd_reg2 = vecs[i].f2;
      #1;
      chk($sformatf("v%0d mem_ready", i),     32'(mem_ready),     32'(vecs[i].mrdy));
      chk($sformatf("v%0d alu_ready", i),     32'(alu_ready),     32'(vecs[i].ardy));
      chk($sformatf("v%0d reg_write", i),     32'(reg_write),     32'(vecs[i].we));
      chk($sformatf("v%0d wr_reg_num", i),    32'(wr_reg_num),    32'(vecs[i].wreg));
      chk($sformatf("v%0d wr_data", i),       wr_data,            vecs[i].wdata);
      chk($sformatf("v%0d pending_count", i), 32'(pending_count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d fwd_hit1", i),      32'(fwd_hit1),      32'(vecs[i].h1));
      chk($sformatf("v%0d fwd_data1", i),     fwd_data1,          vecs[i].d1);
      chk($sformatf("v%0d fwd_hit2", i),      32'(fwd_hit2),      32'(vecs[i].h2));
      chk($sformatf("v%0d fwd_data2", i),     fwd_data2,          vecs[i].d2);
      chk($sformatf("v%0d empty", i),         32'(empty),         32'(vecs[i].emp));
    end

    // Backpressure: both producers stream continuously; model tracks FIFO and port.
    exp_we = 1'b0; exp_reg = '0; exp_data = '0;
    mi = 0; ai = 0; retired = 0; done = 1'b0;
    fwd_reg1 = '0; fwd_reg2 = '0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clock);
      mem_valid = (mi < 4); mem_reg = 5'(2*mi + 1); mem_data = 32'(32'h100 + 2*mi + 1);
      alu_valid = (ai < 4); alu_reg = 5'(2*ai + 2); alu_data = 32'(32'h100 + 2*ai + 2);
      #1;
      em = ((4 - q.size()) >= 1);
      ea = ((4 - q.size()) >= 2) || (((4 - q.size()) == 1) && !mem_valid);
      chk($sformatf("bp%0d mem_ready", cyc),     32'(mem_ready),     32'(em));
      chk($sformatf("bp%0d alu_ready", cyc),     32'(alu_ready),     32'(ea));
      chk($sformatf("bp%0d pending_count", cyc), 32'(pending_count), 32'(q.size()));
      chk($sformatf("bp%0d count_le_depth", cyc), 32'(pending_count <= 3'd4), 32'd1);
      chk($sformatf("bp%0d reg_write", cyc),     32'(reg_write),     32'(exp_we));
      chk($sformatf("bp%0d wr_reg_num", cyc),    32'(wr_reg_num),    32'(exp_reg));
      chk($sformatf("bp%0d wr_data", cyc),       wr_data,            exp_data);
      if (reg_write) retired++;
      if (q.size() > 0) begin
        e = q.pop_front();
        exp_we = 1'b1; exp_reg = e.r; exp_data = e.d;
      end else begin
        exp_we = 1'b0;
      end
      if (mem_valid && em) begin
        e.r = mem_reg; e.d = mem_data; q.push_back(e); mi++;
      end
      if (alu_valid && ea) begin
        e.r = alu_reg; e.d = alu_data; q.push_back(e); ai++;
      end
      done = (mi == 4) && (ai == 4) && (q.size() == 0) && !exp_we;
    end
    mem_valid = 1'b0; alu_valid = 1'b0;
    chk("bp drained", 32'(done), 32'd1);
    chk("bp retired", 32'(retired), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_wb_ctrl.md
Name: reg_wb_ctrl

Overview:
Writeback-side controller for the 32x32 register file write port.
- Accepts register-write requests from two producers, the ALU result path and the load (MEM) path, each over a valid/ready handshake.
- Queues accepted requests in a small in-order FIFO and retires at most one per cycle onto the single write port (wr_reg_num/wr_data/reg_write).
- Exposes a two-operand forwarding lookup so decode never consumes a stale register value while writes are pending.

Parameters:
DEPTH, 4, pending-write FIFO entries (power of 2, >=2)
DATA_W, 32, register data width
ADDR_W, 5, register number width

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  synchronous, active-low
mem_valid  in  1  load writeback request
mem_ready  out  1  MEM request accepted this edge when mem_valid&mem_ready
mem_reg  in  ADDR_W  destination register
mem_data  in  DATA_W  load data
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU accept
alu_reg  in  ADDR_W  destination register
alu_data  in  DATA_W  ALU result
wr_reg_num  out  ADDR_W  register file write address (registered)
wr_data  out  DATA_W  register file write data (registered)
reg_write  out  1  register file write enable (registered)
fwd_reg1, fwd_reg2  in  ADDR_W  operand numbers being read by decode
fwd_hit1, fwd_hit2  out  1  pending newer value exists
fwd_data1, fwd_data2  out  DATA_W  forwarded value (0 when no hit)
pending_count  out  clog2(DEPTH+1)  FIFO occupancy
empty  out  1  FIFO empty and reg_write low

Behaviour:
- Reset (reset==0 at rising edge): FIFO pointers and count cleared; reg_write=0, wr_reg_num=0, wr_data=0; pending_count=0; empty=1.
  - mem_ready and alu_ready are forced 0 while reset is low.
  - Pending entries are discarded on a mid-operation reset, with no partial write. An entry being driven on the write port is cut off at the reset edge.
- free = DEPTH - count, using the registered count.
  - A same-cycle dequeue does not create space (conservative).
  - mem_ready = (free>=1).
  - alu_ready = (free>=2) | (free==1 & ~mem_valid).
- Enqueue at the rising edge on each handshake.
  - When both fire in one cycle, the MEM entry is written first (older) and the ALU entry second (younger). Count rises by up to 2.
  - A request with reg==0 completes its handshake but is discarded: not enqueued, consumes no slot.
- Dequeue: at every rising edge with count>0 (pre-edge state), the head entry is popped into wr_reg_num/wr_data and reg_write=1 for the following cycle.
  - When count==0, reg_write=0 and wr_reg_num/wr_data hold their previous values.
  - Throughput is 1 write/cycle. Enqueue and dequeue in the same edge are both honoured: count += enq - deq.
- Latency: a request accepted at edge E is driven on the write port in the cycle after edge E+1 at the earliest, i.e. 2 edges. Later arrivals wait behind older entries in strict order.
- Forwarding is combinational and evaluated independently per operand.
  - Search space: all valid FIFO entries plus the write-port register when reg_write=1.
  - Age order: write-port register oldest, then FIFO head to tail. The youngest match wins.
  - fwd_reg==0 never hits; fwd_data=0.
  - No match gives hit=0, data=0.
  - Requests being handshaked in the current cycle are not visible to the lookup.
- Wrap-around: pointers are ADDR clog2(DEPTH) bits and wrap naturally. Count distinguishes full from empty.
- Overflow and underflow are impossible by construction. The bench asserts count<=DEPTH every cycle.

Test Plan:
1. Single write: after reset, ALU r5=0xDEADBEEF for one cycle. Required: reg_write=1, wr_reg_num=5, wr_data=0xDEADBEEF exactly 2 edges after accept, one cycle wide. fwd_reg1=5 hits with 0xDEADBEEF while queued and while on the write port.
2. Dual same-cycle: mem r3=0x11111111 and alu r3=0x22222222 both accepted. Required: write port shows 0x11111111 then 0x22222222 on consecutive cycles. fwd_reg1=3 returns 0x22222222 until the second write retires.
3. r0 discard: alu r0=0xFFFFFFFF accepted. Required: pending_count stays 0, reg_write stays 0, and fwd_reg1=0 gives hit=0, data=0.
4. Backpressure (DEPTH=4): hold mem_valid and alu_valid high with distinct regs 1..8 and data. Required:
   - alu_ready drops when free<2 (or free==1 with mem_valid high) and mem_ready drops at free==0.
   - All 8 writes appear in order mem/alu pairwise, with no loss or duplication.
   - pending_count never exceeds 4.
5. Reset mid-operation: fill 3 entries, then assert reset for one edge. Required: next cycle reg_write=0, pending_count=0, both readies 0 during reset, no queued entry ever reaches the write port.
6. Forward priority across stages: r7=0xA on the write port and r7=0xB in the FIFO. Required: fwd_data=0xB. fwd_reg2=8 (absent) gives hit=0, data=0.
